// File: rtl/pwm_duty8_pkg.sv
// pwm_duty8_pkg: shared constants and state type for the PWM duty block.
// Rev 1.0
`default_nettype none
package pwm_duty8_pkg;
  localparam int DUTY_W       = 8;
  localparam int PERIOD_TICKS = 256;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage
`default_nettype wire

// File: rtl/pwm_duty8_prescaler.sv
// pwm_prescaler: free-running divider producing one tick every div+1 enabled cycles.
// Rev 1.0
`default_nettype none
module pwm_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] r_count;

  // >= rather than == so a div reduction below the current count ticks at once.
  assign tick = en && (r_count >= div);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/pwm_duty8.sv
// pwm_duty8: double-buffered 8-bit PWM generator with programmable prescaler.
// Rev 1.0
`default_nettype none
module pwm_duty8
  import pwm_duty8_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DUTY_W-1:0] duty,
  input  logic              load,
  input  logic [DIV_W-1:0]  div,
  output logic              pwm_out,
  output logic              period_start,
  output logic [DUTY_W-1:0] duty_active
);
  state_t            r_state;
  logic [DUTY_W-1:0] r_cnt;
  logic [DUTY_W-1:0] r_shadow;
  logic [DUTY_W-1:0] w_next_shadow;
  logic              w_tick;
  logic              w_run;

  assign w_run         = en && (r_state == RUN);
  // A load coinciding with a period boundary bypasses the shadow.
  assign w_next_shadow = load ? duty : r_shadow;

  pwm_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (w_run),
    .div  (div),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shadow     <= '0;
      duty_active  <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      r_shadow     <= w_next_shadow;
      if (!en) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else if (r_state == IDLE) begin
        r_state      <= RUN;
        duty_active  <= w_next_shadow;
        period_start <= 1'b1;
      end else begin
        pwm_out <= (r_cnt < duty_active);
        if (w_tick) begin
          if (r_cnt == DUTY_W'(PERIOD_TICKS - 1)) begin
            r_cnt        <= '0;
            duty_active  <= w_next_shadow;
            period_start <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pwm_duty8.sv
// tb_pwm_duty8: directed stimulus with a cycle model and per-period literal checks.
// Rev 1.0
`default_nettype none
module tb_pwm_duty8;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             load;
  logic [7:0]       duty;
  logic [DIV_W-1:0] div;
  logic             pwm_out;
  logic             period_start;
  logic [7:0]       duty_active;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwm_duty8 #(.DIV_W(DIV_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .duty         (duty),
    .load         (load),
    .div          (div),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty_active  (duty_active)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: elapsed sub-ticks and ticks within the period, plus the pending/applied duty.
  bit m_valid = 0;
  bit m_run;
  bit m_pwm;
  bit m_ps;
  int m_phase, m_step, m_shadow, m_active;

  always @(posedge clk) begin
    int nxt;
    nxt = load ? int'(duty) : m_shadow;
    if (rst) begin
      m_valid = 1; m_run = 0; m_pwm = 0; m_ps = 0;
      m_phase = 0; m_step = 0; m_shadow = 0; m_active = 0;
    end else if (m_valid) begin
      m_shadow = nxt;
      if (!en) begin
        m_run = 0; m_phase = 0; m_step = 0; m_pwm = 0; m_ps = 0;
      end else if (!m_run) begin
        m_run = 1; m_pwm = 0; m_ps = 1; m_active = nxt;
      end else begin
        m_pwm = (m_step < m_active);
        m_ps  = 0;
        if (m_phase >= int'(div)) begin
          m_phase = 0;
          m_step  = (m_step + 1) % 256;
          if (m_step == 0) begin
            m_active = nxt;
            m_ps     = 1;
          end
        end else begin
          m_phase++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_pwm_out", pwm_out, m_pwm);
      check("model_period_start", period_start, m_ps);
      check("model_duty_active", duty_active, m_active);
    end
  end

  // Samples len cycles from the current negedge, counting high pwm_out samples.
  task automatic run_period(input int len, input int load_at, input int load_val,
                            output int highs, output int ps_next);
    highs = 0;
    for (int i = 0; i < len; i++) begin
      highs += int'(pwm_out);
      if (i == load_at) begin
        load = 1'b1;
        duty = 8'(load_val);
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load    = 1'b0;
    ps_next = int'(period_start);
  endtask

  task automatic wait_ps(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < bound);
    if (!period_start) $display("FAIL wait_period_start actual=timeout required=pulse");
  endtask

  initial begin
    int n, h, h2, p;
    rst = 1'b1; en = 1'b0; duty = 8'hAA; load = 1'b1; div = '0;
    repeat (5) begin
      @(negedge clk);
      check("rst_pwm_out", pwm_out, 0);
      check("rst_period_start", period_start, 0);
      check("rst_duty_active", duty_active, 0);
    end
    rst = 1'b0; duty = 8'd64;
    @(negedge clk);
    load = 1'b0; en = 1'b1;
    wait_ps(10, n);
    check("first_ps_latency", n, 1);
    run_period(256, -1, 0, h, p);
    check("duty64_high", h, 64);
    check("duty64_period", p, 1);

    run_period(255, 100, 192, h, p);
    check("defer_hold_active", duty_active, 64);
    run_period(1, -1, 0, h2, p);
    check("defer_cur_high", h + h2, 64);
    check("defer_period", p, 1);
    check("defer_new_active", duty_active, 192);

    run_period(256, 255, 10, h, p);
    check("duty192_high", h, 192);
    check("bypass_active", duty_active, 10);
    run_period(256, -1, 0, h, p);
    check("bypass_high", h, 10);
    check("shadow_kept_active", duty_active, 10);

    run_period(256, 5, 0, h, p);
    run_period(256, -1, 0, h, p);
    check("duty0_high", h, 0);

    div = 8'd3;
    run_period(1024, 0, 255, h, p);
    check("div3_period", p, 1);
    run_period(1024, -1, 0, h, p);
    check("duty255_div3_high", h, 1020);
    check("duty255_div3_period", p, 1);

    repeat (2) @(negedge clk);
    div = '0;
    wait_ps(2000, n);
    check("div_shrink_len", n + 2, 258);

    run_period(50, -1, 0, h, p);
    en = 1'b0;
    @(negedge clk);
    check("disable_pwm_out", pwm_out, 0);
    check("disable_period_start", period_start, 0);
    check("disable_active_held", duty_active, 255);
    repeat (3) @(negedge clk);
    en = 1'b1;
    wait_ps(10, n);
    check("reenable_ps_latency", n, 1);
    run_period(256, -1, 0, h, p);
    check("reenable_high", h, 255);
    check("reenable_period", p, 1);

    run_period(30, -1, 0, h, p);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_pwm_out", pwm_out, 0);
      check("midrst_period_start", period_start, 0);
      check("midrst_duty_active", duty_active, 0);
    end
    rst = 1'b0;
    wait_ps(10, n);
    check("post_rst_ps_latency", n, 1);
    run_period(256, -1, 0, h, p);
    check("post_rst_high", h, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
